instr_mem_fetch: RTL

// - Clocked, parametrised instruction memory for the 5-stage ARMv8 pipeline; successor to the combinational ROM.
// - Accepts one fetch per cycle from IF (1-cycle registered latency); returns 32-bit instruction + valid.
// - Supports in-system program load, stall hold, branch flush (NOP injection), and misaligned/out-of-range fault flag.
// - Sits between PC register and IF/ID pipeline register.

---
 rtl/instr_mem_fetch_pkg.sv | 21 ++
 rtl/instr_mem_fetch_if.sv | 28 ++
 rtl/instr_mem_fetch_imem_bank.sv | 31 +++
 rtl/instr_mem_fetch.sv | 65 ++++++
 4 files changed

// File: rtl/instr_mem_fetch_pkg.sv
// Shared constants, the output-controller mode type and the address legality helper
// used by the instruction fetch memory and its testbench.
package instr_mem_fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  // ADD XZR,XZR,XZR: returned for bubbles, flushes, faults and unwritten words.
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h8B1F03FF;

  typedef enum logic {
    OUT_HOLD,
    OUT_UPDATE
  } out_mode_e;

  // Word aligned and below depth*4, compared unsigned on the full address width.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < (ADDR_W'(depth) << 2));
  endfunction

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Fetch and program-load signal bundle between the IF stage (master) and the
// instruction memory (slave).
interface instr_mem_fetch_if;
  import instr_mem_fetch_pkg::*;

  logic               FetchReq;
  logic [ADDR_W-1:0]  FetchAddr;
  logic               FetchReady;
  logic               Stall;
  logic               Flush;
  logic [INSTR_W-1:0] Instruction;
  logic               InstrValid;
  logic               Fault;
  logic               ProgWrEn;
  logic [ADDR_W-1:0]  ProgAddr;
  logic [INSTR_W-1:0] ProgData;

  modport master (
    output FetchReq, FetchAddr, Stall, Flush, ProgWrEn, ProgAddr, ProgData,
    input  FetchReady, Instruction, InstrValid, Fault
  );

  modport slave (
    input  FetchReq, FetchAddr, Stall, Flush, ProgWrEn, ProgAddr, ProgData,
    output FetchReady, Instruction, InstrValid, Fault
  );

endinterface

// File: rtl/instr_mem_fetch_imem_bank.sv
// DEPTH x DATA_W instruction array with one synchronous read port and one
// synchronous write port; a same-edge read of the written word sees the old data.
module imem_bank
  import instr_mem_fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int          DATA_W = INSTR_W
) (
  input  logic                     CLK,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata
);

  // NOTE: the array has no reset port so it maps onto block RAM; the declaration
  // initialiser gives power-up contents of NOP_WORD and Reset leaves them alone.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: DATA_W'(NOP_WORD)};
  logic [DATA_W-1:0] r_rdata = DATA_W'(NOP_WORD);

  // NOTE: non-blocking read and write in one block give read-before-write for free.
  always_ff @(posedge CLK) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_fetch.sv
// Clocked instruction memory for the IF stage: 1-cycle fetch latency, program
// load port, stall hold, flush-to-NOP and misaligned/out-of-range fault flag.
module instr_mem_fetch
  import instr_mem_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic             CLK,
  input  logic             Reset,
  instr_mem_fetch_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic               w_fetch_ok;
  logic               w_prog_ok;
  logic               w_accept;
  logic               w_read;
  out_mode_e          w_mode;
  logic [INSTR_W-1:0] w_rdata;

  logic r_from_mem;
  logic r_valid;
  logic r_fault;

  assign w_fetch_ok = addr_ok(bus.FetchAddr, DEPTH);
  assign w_prog_ok  = addr_ok(bus.ProgAddr, DEPTH);

  assign bus.FetchReady = !bus.Stall && !Reset;
  // A flushed request is dropped even though FetchReady still shows !Stall.
  assign w_accept = bus.FetchReq && bus.FetchReady && !bus.Flush;
  assign w_read   = w_accept && w_fetch_ok;
  assign w_mode   = (bus.Stall && !bus.Flush) ? OUT_HOLD : OUT_UPDATE;

  imem_bank #(
    .DEPTH (DEPTH),
    .DATA_W(INSTR_W)
  ) u_bank (
    .CLK    (CLK),
    .i_re   (w_read),
    .i_raddr(bus.FetchAddr[IDX_W+1:2]),
    .o_rdata(w_rdata),
    .i_we   (bus.ProgWrEn && w_prog_ok),
    .i_waddr(bus.ProgAddr[IDX_W+1:2]),
    .i_wdata(bus.ProgData)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_from_mem <= 1'b0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else if (w_mode == OUT_UPDATE) begin
      r_from_mem <= w_read;
      r_valid    <= w_accept;
      r_fault    <= w_accept && !w_fetch_ok;
    end
  end

  // The bank's read register only loads on an accepted fetch, so it holds across stalls.
  assign bus.Instruction = r_from_mem ? w_rdata : NOP_WORD;
  assign bus.InstrValid  = r_valid;
  assign bus.Fault       = r_fault;

endmodule
